// File: rtl/pc_redirect_unit_if.sv
// Purpose: bundles the redirect sources, the fetch handshake and the status
//          outputs of pc_redirect_unit into one interface.
// Ports:   master = PC generator side (drives pc/pc_valid/squash/status),
//          slave  = environment side (drives redirects and fetch_ready).
interface pc_redirect_unit_if #(
  parameter int XLEN    = 64,
  parameter int NUM_SRC = 4,
  parameter int CNT_W   = 32
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]           redir_valid;
  logic [NUM_SRC-1:0][XLEN-1:0] redir_target;
  logic                         fetch_ready;
  logic [XLEN-1:0]              pc;
  logic                         pc_valid;
  logic                         squash;
  logic                         redir_taken;
  logic [SRC_W-1:0]             redir_src;
  logic                         misaligned;
  logic [CNT_W-1:0]             redir_count;

  modport master (
    input  redir_valid, redir_target, fetch_ready,
    output pc, pc_valid, squash, redir_taken, redir_src, misaligned, redir_count
  );

  modport slave (
    output redir_valid, redir_target, fetch_ready,
    input  pc, pc_valid, squash, redir_taken, redir_src, misaligned, redir_count
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// Purpose: fetch PC generator with prioritised N-way redirect and squash flag.
// Latency: redirect target on pc one cycle after the pulse (or after first ready).
// Backpressure: while fetch_ready=0 the pc is held and the best redirect is parked.
// Ports:   clk, resetn (async active-low), bus (pc_redirect_unit_if.master):
//          redir_valid/redir_target in, fetch_ready in, pc/pc_valid/squash out,
//          redir_taken/redir_src/misaligned pulses, redir_count saturating count.
module pc_redirect_unit #(
  parameter int              XLEN       = 64,
  parameter int              NUM_SRC    = 4,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(64'h8000_0000),
  parameter int              INST_BYTES = 4,
  parameter int              CNT_W      = 32
) (
  input logic               clk,
  input logic               resetn,
  pc_redirect_unit_if.master bus
);
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_PEND} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  pend_tgt_q, pend_tgt_d;
  logic [SRC_W-1:0] pend_src_q, pend_src_d;
  logic             pc_valid_q, pc_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             win_vld;
  logic [SRC_W-1:0] win;
  logic [XLEN-1:0]  win_raw, win_tgt, load_tgt;
  logic             ovr;
  logic             squash, taken;
  logic [SRC_W-1:0] taken_src;

  // Arbitration: scanning from the top down leaves the lowest asserted index.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.redir_valid[i]) begin
        win_vld = 1'b1;
        win     = SRC_W'(i);
      end
    end
    win_raw = bus.redir_target[win];
    win_tgt = {win_raw[XLEN-1:2], 2'b00};
    // A new redirect may replace the parked one only at equal or higher priority.
    ovr     = win_vld && (win <= pend_src_q);
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_tgt_q <= '0;
      pend_src_q <= '0;
      pc_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      pend_src_q <= pend_src_d;
      pc_valid_q <= pc_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  // Output logic: squash and redirect-taken decode.
  always_comb begin
    squash    = 1'b0;
    taken     = 1'b0;
    taken_src = win;
    load_tgt  = win_tgt;
    unique case (state_q)
      ST_BOOT: begin
        // No request is outstanding yet, so a redirect needs no squash.
        taken = win_vld;
      end
      ST_RUN: begin
        if (win_vld && bus.fetch_ready) begin
          squash = 1'b1;
          taken  = 1'b1;
        end
      end
      ST_PEND: begin
        if (bus.fetch_ready) begin
          squash = 1'b1;
          taken  = 1'b1;
          if (!ovr) begin
            taken_src = pend_src_q;
            load_tgt  = pend_tgt_q;
          end
        end
      end
      default: ;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    pend_src_d = pend_src_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (win_vld && !bus.fetch_ready) begin
          state_d    = ST_PEND;
          pend_src_d = win;
          pend_tgt_d = win_tgt;
        end else if (bus.fetch_ready && !win_vld) begin
          pc_d = pc_q + XLEN'(INST_BYTES);
        end
      end
      ST_PEND: begin
        if (bus.fetch_ready) begin
          state_d = ST_RUN;
        end else if (ovr) begin
          pend_src_d = win;
          pend_tgt_d = win_tgt;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    if (taken) begin
      pc_d = load_tgt;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
    pc_valid_d = (state_d != ST_BOOT);
  end

  assign bus.pc          = pc_q;
  assign bus.pc_valid    = pc_valid_q;
  assign bus.squash      = squash;
  assign bus.redir_taken = taken;
  assign bus.redir_src   = taken_src;
  assign bus.misaligned  = win_vld && (win_raw[1:0] != 2'b00);
  assign bus.redir_count = cnt_q;
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Purpose: scoreboard bench for pc_redirect_unit with directed and random stimulus.
// Latency: expected outputs are queued per cycle and compared at the falling edge.
// Backpressure: fetch_ready is driven directly (directed and random patterns).
module tb_pc_redirect_unit;
  localparam int          XLEN     = 64;
  localparam int          NSRC     = 4;
  localparam int          CW       = 2;
  localparam logic [63:0] RST_PC   = 64'h8000_0000;
  localparam int          CNT_MAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pc_redirect_unit_if #(.XLEN(XLEN), .NUM_SRC(NSRC), .CNT_W(CW)) bus ();

  pc_redirect_unit #(.XLEN(XLEN), .NUM_SRC(NSRC), .RESET_PC(RST_PC),
                     .INST_BYTES(4), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  typedef struct {
    logic [63:0] pc;
    logic        valid;
    logic        squash;
    logic        taken;
    logic [1:0]  src;
    logic        mis;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: "booting", current fetch address, optional parked redirect.
  bit          m_boot;
  logic [63:0] m_pc;
  bit          m_pend;
  int          m_psrc;
  logic [63:0] m_ptgt;
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1; m_pc = RST_PC; m_pend = 1'b0; m_psrc = 0; m_ptgt = '0; m_cnt = 0;
  endtask

  // Apply one cycle of inputs, queue what the DUT must show, advance the model.
  task automatic go(input logic [3:0] v, input logic [3:0][63:0] t, input bit r);
    exp_t e;
    int   win;
    bit   any;
    bit   take_new;
    logic [63:0] wt;
    bus.redir_valid  = v;
    bus.redir_target = t;
    bus.fetch_ready  = r;
    any = (v != 4'b0);
    win = 0;
    for (int i = 3; i >= 0; i--) if (v[i]) win = i;
    wt = t[win];
    e.pc = m_pc; e.cnt = m_cnt; e.valid = !m_boot;
    e.mis = any && (wt[1:0] != 2'b00);
    wt = wt & ~64'h3;
    e.squash = 1'b0; e.taken = 1'b0; e.src = 2'(win);
    if (m_boot) begin
      if (any) begin e.taken = 1'b1; m_pc = wt; end
      m_boot = 1'b0;
    end else if (!m_pend) begin
      if (any && r) begin e.squash = 1'b1; e.taken = 1'b1; m_pc = wt; end
      else if (r) m_pc = m_pc + 64'd4;
      else if (any) begin m_pend = 1'b1; m_psrc = win; m_ptgt = wt; end
    end else begin
      take_new = any && (win <= m_psrc);
      if (r) begin
        e.squash = 1'b1; e.taken = 1'b1;
        e.src = 2'(take_new ? win : m_psrc);
        m_pc = take_new ? wt : m_ptgt;
        m_pend = 1'b0;
      end else if (take_new) begin
        m_psrc = win; m_ptgt = wt;
      end
    end
    if (e.taken && m_cnt < CNT_MAX) m_cnt++;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: DUT presents a fetch-port/status view each cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc", bus.pc, e.pc);
      chk("pc_valid", 64'(bus.pc_valid), 64'(e.valid));
      chk("squash", 64'(bus.squash), 64'(e.squash));
      chk("redir_taken", 64'(bus.redir_taken), 64'(e.taken));
      if (e.taken) chk("redir_src", 64'(bus.redir_src), 64'(e.src));
      chk("misaligned", 64'(bus.misaligned), 64'(e.mis));
      chk("redir_count", 64'(bus.redir_count), 64'(e.cnt));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0][63:0] t;
    logic [3:0]       v;
    bit               r;
    t = '0;
    bus.redir_valid = '0; bus.redir_target = '0; bus.fetch_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", bus.pc, RST_PC);
    chk("reset_pc_valid", 64'(bus.pc_valid), 64'd0);
    chk("reset_count", 64'(bus.redir_count), 64'd0);
    resetn = 1'b1;

    // Boot and sequential fetch.
    repeat (4) go(4'b0000, t, 1'b1);
    // Two simultaneous sources: src1 beats src3.
    t = '0; t[1] = 64'h100; t[3] = 64'h300;
    go(4'b1010, t, 1'b1);
    go(4'b0000, t, 1'b1);
    // Back-pressure: park src2, ignore lower-priority src3, src0 overrides.
    t = '0; t[2] = 64'h200;
    go(4'b0100, t, 1'b0);
    go(4'b0000, t, 1'b0);
    go(4'b0000, t, 1'b0);
    t = '0; t[3] = 64'h300;
    go(4'b1000, t, 1'b0);
    t = '0; t[0] = 64'h80;
    go(4'b0001, t, 1'b0);
    go(4'b0000, t, 1'b1);
    go(4'b0000, t, 1'b1);
    // Misaligned target has its low bits dropped.
    t = '0; t[0] = 64'h203;
    go(4'b0001, t, 1'b1);
    go(4'b0000, t, 1'b1);
    // Wrap-around at the top of the address space; counter saturates.
    t = '0; t[0] = 64'hFFFF_FFFF_FFFF_FFFC;
    go(4'b0001, t, 1'b1);
    go(4'b0000, t, 1'b1);
    go(4'b0000, t, 1'b1);
    t = '0; t[1] = 64'h40;
    go(4'b0010, t, 1'b1);
    go(4'b0000, t, 1'b1);

    // Reset while a redirect is parked.
    t = '0; t[2] = 64'h500;
    go(4'b0100, t, 1'b0);
    go(4'b0000, t, 1'b0);
    bus.redir_valid = '0;
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_pc", bus.pc, RST_PC);
    chk("async_rst_pc_valid", 64'(bus.pc_valid), 64'd0);
    chk("async_rst_squash", 64'(bus.squash), 64'd0);
    chk("async_rst_taken", 64'(bus.redir_taken), 64'd0);
    chk("async_rst_count", 64'(bus.redir_count), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
    repeat (4) go(4'b0000, t, 1'b1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < 4; s++) begin
        v[s] = ($urandom_range(0, 4) == 0);
        t[s] = {$urandom, $urandom};
      end
      r = ($urandom_range(0, 9) < 7);
      go(v, t, r);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
